inst_fetch_queue: RTL

Parametrised instruction fetch queue between PC/address-translation logic and the decode stage. Replaces the single-outstanding fetch path with a DEPTH-entry in-order ring. It supports up to MAX_OUT outstanding bus reads, queues translation exceptions in program order, and flushes on commit or branch. Responses to requests issued before a flush are discarded in order.

---
 rtl/inst_fetch_queue_pkg.sv | 19 +
 rtl/inst_fetchq_ram.sv | 48 ++++
 rtl/inst_fetch_queue.sv | 137 +++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue: exception field layout
// and the metadata word format (pc in the upper bits, exception bits below).
package inst_fetch_queue_pkg;

  localparam int EXCCODE_W    = 5;
  localparam int EXC_W        = EXCCODE_W + 2;
  localparam int EXC_CODE_LSB = 0;
  localparam int EXC_MISS_BIT = EXCCODE_W;
  localparam int EXC_FLAG_BIT = EXCCODE_W + 1;
  localparam int META_W       = 32 + EXC_W;

  // Packs the exception flag, refill flavour and code into the stored layout.
  function automatic logic [EXC_W-1:0] pack_exc(input logic exc,
                                                input logic miss,
                                                input logic [EXCCODE_W-1:0] code);
    return {exc, miss, code};
  endfunction

endpackage

// File: rtl/inst_fetchq_ram.sv
// Storage for the fetch queue: a pc+exception metadata array written at
// allocation and an instruction array written when the word returns.
// Both arrays read combinationally at the queue head.
module inst_fetchq_ram
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              meta_we,
  input  logic [AW-1:0]     meta_waddr,
  input  logic [META_W-1:0] meta_wdata,
  input  logic              inst_we,
  input  logic [AW-1:0]     inst_waddr,
  input  logic [31:0]       inst_wdata,
  input  logic [AW-1:0]     raddr,
  output logic [META_W-1:0] meta_rdata,
  output logic [31:0]       inst_rdata
);

  logic [META_W-1:0] meta_q [DEPTH];
  logic [META_W-1:0] meta_d [DEPTH];
  logic [31:0]       inst_q [DEPTH];
  logic [31:0]       inst_d [DEPTH];

  // Metadata write port: one entry per allocation.
  always_comb begin
    meta_d = meta_q;
    if (meta_we) meta_d[meta_waddr] = meta_wdata;
  end

  // Instruction write port: one entry per fill (or zero for exception entries).
  always_comb begin
    inst_d = inst_q;
    if (inst_we) inst_d[inst_waddr] = inst_wdata;
  end

  // Array state; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    meta_q <= meta_d;
    inst_q <= inst_d;
  end

  assign meta_rdata = meta_q[raddr];
  assign inst_rdata = inst_q[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// In-order instruction fetch queue with up to MAX_OUT outstanding bus reads.
// Flushes redirect all pointers to wptr; responses for requests issued before
// a flush are counted off in 'discard' and dropped in order.
// Optional build macro INST_FETCHQ_BYPASS_EN forwards a returning word straight
// to the decode outputs when the queue has no completed entry at its head.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [31:0]          req_pc_i,
  input  logic [31:0]          req_paddr_i,
  input  logic                 req_cache_i,
  input  logic                 req_exc_i,
  input  logic                 req_exc_miss_i,
  input  logic [EXCCODE_W-1:0] req_exccode_i,
  output logic                 inst_req,
  output logic                 inst_cache,
  output logic [31:0]          inst_addr,
  input  logic                 inst_addr_ok,
  input  logic [31:0]          inst_rdata,
  input  logic                 inst_data_ok,
  input  logic                 flush_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [31:0]          pc_o,
  output logic [31:0]          inst_o,
  output logic                 exc_o,
  output logic                 exc_miss_o,
  output logic [EXCCODE_W-1:0] exccode_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = $clog2(MAX_OUT + 1);

  logic [PW-1:0] rptr_q, rptr_d, rsp_ptr_q, rsp_ptr_d, wptr_q, wptr_d;
  logic [DW-1:0] discard_q, discard_d;

  logic [PW-1:0]     occ, inflight;
  logic              discard_zero, rsp_valid, fill, bypass_hit, pop, space;
  logic              out_ok, exc_accept, bus_fire, alloc;
  logic [META_W-1:0] meta_rd, meta_wdata;
  logic [31:0]       ram_inst;

  assign occ          = wptr_q - rptr_q;
  assign inflight     = wptr_q - rsp_ptr_q;
  assign discard_zero = (discard_q == '0);
  // A data_ok with nothing outstanding is a bus protocol error and is ignored.
  assign rsp_valid    = inst_data_ok & (~discard_zero | (inflight != '0));
  assign fill         = rsp_valid & discard_zero & ~flush_i;

`ifdef INST_FETCHQ_BYPASS_EN
  assign bypass_hit = (rptr_q == rsp_ptr_q) & (inflight != '0) & discard_zero
                      & inst_data_ok & ~flush_i;
`else
  assign bypass_hit = 1'b0;
`endif

  assign valid_o = resetn & ~flush_i & ((rptr_q != rsp_ptr_q) | bypass_hit);
  assign pop     = valid_o & ready_i;
  assign space   = (occ < PW'(DEPTH)) | ((occ == PW'(DEPTH)) & pop);
  assign out_ok  = (32'(inflight) + 32'(discard_q)) < 32'(MAX_OUT);

  assign inst_req    = resetn & req_valid_i & ~req_exc_i & space & out_ok & ~flush_i;
  assign exc_accept  = resetn & req_valid_i & req_exc_i & space & (inflight == '0) & ~flush_i;
  assign bus_fire    = inst_req & inst_addr_ok;
  assign alloc       = bus_fire | exc_accept;
  assign req_ready_o = alloc;
  assign inst_cache  = req_cache_i;
  assign inst_addr   = req_paddr_i;

  assign meta_wdata = {req_pc_i, exc_accept ? pack_exc(1'b1, req_exc_miss_i, req_exccode_i)
                                            : pack_exc(1'b0, 1'b0, '0)};

  // Pointer and discard-counter next state; a flush overrides everything else.
  always_comb begin
    rptr_d    = rptr_q;
    rsp_ptr_d = rsp_ptr_q;
    wptr_d    = wptr_q;
    discard_d = discard_q;
    if (flush_i) begin
      rptr_d    = wptr_q;
      rsp_ptr_d = wptr_q;
      // Everything still on the bus, minus a response consumed this cycle.
      discard_d = DW'(32'(discard_q) + 32'(inflight) - 32'(rsp_valid));
    end else begin
      if (alloc)                     wptr_d    = wptr_q + PW'(1);
      if (exc_accept || fill)        rsp_ptr_d = rsp_ptr_q + PW'(1);
      if (rsp_valid && !discard_zero) discard_d = discard_q - DW'(1);
      if (pop)                       rptr_d    = rptr_q + PW'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rptr_q    <= '0;
      rsp_ptr_q <= '0;
      wptr_q    <= '0;
      discard_q <= '0;
    end else begin
      rptr_q    <= rptr_d;
      rsp_ptr_q <= rsp_ptr_d;
      wptr_q    <= wptr_d;
      discard_q <= discard_d;
    end
  end

  inst_fetchq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk        (clk),
    .meta_we    (alloc),
    .meta_waddr (wptr_q[AW-1:0]),
    .meta_wdata (meta_wdata),
    .inst_we    (fill | exc_accept),
    .inst_waddr (rsp_ptr_q[AW-1:0]),
    .inst_wdata (exc_accept ? 32'h0 : inst_rdata),
    .raddr      (rptr_q[AW-1:0]),
    .meta_rdata (meta_rd),
    .inst_rdata (ram_inst)
  );

  assign pc_o       = meta_rd[META_W-1 -: 32];
  assign inst_o     = bypass_hit ? inst_rdata : ram_inst;
  assign exc_o      = meta_rd[EXC_FLAG_BIT];
  assign exc_miss_o = meta_rd[EXC_MISS_BIT];
  assign exccode_o  = meta_rd[EXC_CODE_LSB +: EXCCODE_W];

  a_data_ok_expected: assert property (@(posedge clk) disable iff (!resetn)
    inst_data_ok |-> ((inflight != '0) || !discard_zero));

endmodule
